// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined execute-stage ALU: opcodes, shifter modes,
// flag bit positions and the per-opcode flag write mask.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD    = 3'd0,
    ALU_SUB    = 3'd1,
    ALU_RED    = 3'd2,
    ALU_XOR    = 3'd3,
    ALU_SLL    = 3'd4,
    ALU_SRA    = 3'd5,
    ALU_ROR    = 3'd6,
    ALU_PADDSB = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    SH_SLL = 2'd0,
    SH_SRA = 2'd1,
    SH_ROR = 2'd2
  } shift_mode_e;

  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_V = 0;

  // Which of {N,Z,V} an opcode is allowed to overwrite when it reaches S2.
  function automatic logic [2:0] flag_wmask(input alu_op_e op);
    logic [2:0] m;
    m = '0;
    case (op)
      ALU_ADD, ALU_SUB:                   m = '1;
      ALU_XOR, ALU_SLL, ALU_SRA, ALU_ROR: m[FLAG_Z] = 1'b1;
      default:                            m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/alu_shifter_p.sv
// Log-stage barrel shifter: logical left, arithmetic right, or rotate right by amt.
module alu_shifter_p
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0]         din,
  input  logic [$clog2(WIDTH)-1:0] amt,
  input  logic [1:0]               mode,
  output logic [WIDTH-1:0]         dout
);

  localparam int unsigned SW = $clog2(WIDTH);

  logic [WIDTH-1:0] stg [SW+1];

  assign stg[0] = din;

  for (genvar i = 0; i < SW; i++) begin : g_stage
    localparam int unsigned SH = 1 << i;
    logic [WIDTH-1:0] shifted;

    always_comb begin
      case (mode)
        SH_SRA:  shifted = {{SH{stg[i][WIDTH-1]}}, stg[i][WIDTH-1:SH]};
        SH_ROR:  shifted = {stg[i][SH-1:0], stg[i][WIDTH-1:SH]};
        default: shifted = {stg[i][WIDTH-1-SH:0], {SH{1'b0}}};
      endcase
    end

    assign stg[i+1] = amt[i] ? shifted : stg[i];
  end

  assign dout = stg[SW];

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready on both sides and an NZV flag register
// updated in issue order as each op loads the output stage.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned LANE   = 4,
  parameter int unsigned SAT_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       flag
);

  localparam int unsigned SW     = $clog2(WIDTH);
  localparam int unsigned M      = WIDTH - 1;
  localparam int unsigned NBYTES = 2 * WIDTH / 8;
  localparam int unsigned NLANES = WIDTH / LANE;

  logic             s1_valid;
  alu_op_e          s1_op;
  logic [WIDTH-1:0] s1_a, s1_b;

  logic s2_ready, s1_advance, accept;

  assign s2_ready   = !out_valid || out_ready;
  assign s1_advance = s1_valid && s2_ready;
  assign in_ready   = !flush && (!s1_valid || s1_advance);
  assign accept     = in_valid && in_ready;

  // Saturating add/sub; overflow direction follows the sign of operand A.
  logic [WIDTH-1:0] add_raw, add_res;
  logic             add_ovf, is_sub;

  assign is_sub = (s1_op == ALU_SUB);

  always_comb begin
    add_raw = is_sub ? (s1_a - s1_b) : (s1_a + s1_b);
    add_ovf = (is_sub ? (s1_a[M] != s1_b[M]) : (s1_a[M] == s1_b[M])) && (add_raw[M] != s1_a[M]);
    add_res = add_raw;
    if ((SAT_EN != 0) && add_ovf)
      add_res = s1_a[M] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end

  logic [2*WIDTH-1:0] red_src;
  logic [WIDTH-1:0]   red_byte [NBYTES];
  logic [WIDTH-1:0]   red_sum;

  assign red_src = {s1_b, s1_a};

  for (genvar b = 0; b < NBYTES; b++) begin : g_red
    assign red_byte[b] = {{(WIDTH-8){red_src[8*b+7]}}, red_src[8*b +: 8]};
  end

  always_comb begin
    red_sum = '0;
    for (int unsigned k = 0; k < NBYTES; k++)
      red_sum = red_sum + red_byte[k];
  end

  // Each lane adds with one guard bit; guard and sign disagreeing means overflow.
  logic [WIDTH-1:0] padd_res;

  for (genvar l = 0; l < NLANES; l++) begin : g_lane
    logic [LANE:0] s;
    assign s = {s1_a[l*LANE+LANE-1], s1_a[l*LANE +: LANE]}
             + {s1_b[l*LANE+LANE-1], s1_b[l*LANE +: LANE]};
    assign padd_res[l*LANE +: LANE] = (s[LANE] == s[LANE-1]) ? s[LANE-1:0]
                                    : {s[LANE], {(LANE-1){!s[LANE]}}};
  end

  logic [1:0]       sh_mode;
  logic [WIDTH-1:0] sh_res;

  always_comb begin
    case (s1_op)
      ALU_SRA: sh_mode = SH_SRA;
      ALU_ROR: sh_mode = SH_ROR;
      default: sh_mode = SH_SLL;
    endcase
  end

  alu_shifter_p #(.WIDTH(WIDTH)) u_shifter (
    .din  (s1_a),
    .amt  (s1_b[SW-1:0]),
    .mode (sh_mode),
    .dout (sh_res)
  );

  logic [WIDTH-1:0] result;
  logic [2:0]       new_flag, wmask;

  always_comb begin
    case (s1_op)
      ALU_ADD, ALU_SUB:          result = add_res;
      ALU_RED:                   result = red_sum;
      ALU_XOR:                   result = s1_a ^ s1_b;
      ALU_SLL, ALU_SRA, ALU_ROR: result = sh_res;
      ALU_PADDSB:                result = padd_res;
      default:                   result = '0;
    endcase
    new_flag         = '0;
    new_flag[FLAG_N] = result[M];
    new_flag[FLAG_Z] = (result == '0);
    new_flag[FLAG_V] = add_ovf;
    wmask            = flag_wmask(s1_op);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_op     <= ALU_ADD;
      s1_a      <= '0;
      s1_b      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      flag      <= '0;
    end else if (flush) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_op    <= alu_op_e'(op);
        s1_a     <= in1;
        s1_b     <= in2;
      end else if (s1_advance) begin
        s1_valid <= 1'b0;
      end
      if (s1_advance) begin
        out_valid <= 1'b1;
        out_data  <= result;
        flag      <= (flag & ~wmask) | (new_flag & wmask);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed vectors, randomized traffic against a
// behavioural model, backpressure, flush and mid-stream reset.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in1, in2, out_data;
  logic [2:0]  op, flag;
  logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready;
  logic [15:0] w_out_data;
  logic [2:0]  w_flag;

  int          total = 0;
  int          bad   = 0;
  logic [2:0]  mflag;

  typedef struct packed {
    logic [2:0]  o;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
    logic [2:0]  f;
  } dcase_t;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(16), .LANE(4), .SAT_EN(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .flag(flag)
  );

  alu_pipe #(.WIDTH(16), .LANE(4), .SAT_EN(0)) dut_wrap (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in1(in1), .in2(in2), .op(op), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .out_data(w_out_data), .flag(w_flag)
  );

  // Behavioural model: signed integer arithmetic with explicit clamping.
  task automatic ref_op(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] fin, output logic [15:0] r, output logic [2:0] fout);
    int sa, sb, t, x, y;
    logic [31:0] d;
    logic v;
    sa = $signed(a); sb = $signed(b);
    fout = fin; r = '0; v = 1'b0;
    case (o)
      3'd0, 3'd1: begin
        t = (o == 3'd0) ? sa + sb : sa - sb;
        v = (t > 32767) || (t < -32768);
        if (t > 32767) r = 16'h7FFF;
        else if (t < -32768) r = 16'h8000;
        else r = t[15:0];
        fout = {r[15], r == 16'h0, v};
      end
      3'd2: begin
        t = 0;
        for (int k = 0; k < 2; k++) begin
          x = $signed(a[8*k +: 8]);
          y = $signed(b[8*k +: 8]);
          t = t + x + y;
        end
        r = t[15:0];
      end
      3'd3: begin r = a ^ b; fout[1] = (r == 16'h0); end
      3'd4: begin r = a << b[3:0]; fout[1] = (r == 16'h0); end
      3'd5: begin r = $signed(a) >>> b[3:0]; fout[1] = (r == 16'h0); end
      3'd6: begin d = {a, a} >> b[3:0]; r = d[15:0]; fout[1] = (r == 16'h0); end
      default: begin
        for (int l = 0; l < 4; l++) begin
          x = $signed(a[4*l +: 4]) + $signed(b[4*l +: 4]);
          if (x > 7) x = 7;
          if (x < -8) x = -8;
          r[4*l +: 4] = x[3:0];
        end
      end
    endcase
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 7))
      0: return 16'h7FFF;
      1: return 16'h8000;
      2: return 16'h0000;
      3: return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // Issues one op into an idle pipeline and waits (bounded) for its result.
  task automatic run_one(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] r, output logic [2:0] f, output int lat);
    logic [15:0] mr;
    @(negedge clk);
    op = o; in1 = a; in2 = b; in_valid = 1'b1; out_ready = 1'b1;
    ref_op(o, a, b, mflag, mr, mflag);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    r = out_data; f = flag;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    w_in_valid = 1'b0; w_out_ready = 1'b1;
    in1 = '0; in2 = '0; op = '0;
    repeat (2) @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (flag !== 3'b000) begin bad++; $display("FAIL reset_flag: got %b want 000", flag); end
    total++; if (out_data !== 16'h0) begin bad++; $display("FAIL reset_out_data: got %h want 0000", out_data); end
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    mflag = 3'b000;
  endtask

  task automatic test_directed();
    dcase_t dc [12];
    logic [15:0] r;
    logic [2:0] f;
    int lat;
    dc[0]  = '{3'd0, 16'h7FFF, 16'h0001, 16'h7FFF, 3'b001};
    dc[1]  = '{3'd1, 16'h8000, 16'h0001, 16'h8000, 3'b101};
    dc[2]  = '{3'd3, 16'h00FF, 16'h00FF, 16'h0000, 3'b111};
    dc[3]  = '{3'd7, 16'h7878, 16'h1111, 16'h7979, 3'b111};
    dc[4]  = '{3'd2, 16'h0102, 16'h03FF, 16'h0005, 3'b111};
    dc[5]  = '{3'd5, 16'h8000, 16'h0004, 16'hF800, 3'b101};
    dc[6]  = '{3'd6, 16'h1234, 16'h0004, 16'h4123, 3'b101};
    dc[7]  = '{3'd4, 16'h0001, 16'h000F, 16'h8000, 3'b101};
    dc[8]  = '{3'd4, 16'hABCD, 16'h0000, 16'hABCD, 3'b101};
    dc[9]  = '{3'd1, 16'h0005, 16'h0005, 16'h0000, 3'b010};
    dc[10] = '{3'd6, 16'h1234, 16'h0000, 16'h1234, 3'b000};
    dc[11] = '{3'd0, 16'h8000, 16'hFFFF, 16'h8000, 3'b101};
    for (int i = 0; i < 12; i++) begin
      run_one(dc[i].o, dc[i].a, dc[i].b, r, f, lat);
      total++; if (r !== dc[i].r) begin bad++; $display("FAIL directed_data[%0d]: got %h want %h", i, r, dc[i].r); end
      total++; if (f !== dc[i].f) begin bad++; $display("FAIL directed_flag[%0d]: got %b want %b", i, f, dc[i].f); end
      total++; if (lat != 2) begin bad++; $display("FAIL directed_latency[%0d]: got %0d want 2", i, lat); end
    end
  endtask

  task automatic test_sat_off();
    int n;
    @(negedge clk);
    op = 3'd0; in1 = 16'h7FFF; in2 = 16'h0001; w_in_valid = 1'b1;
    @(negedge clk);
    w_in_valid = 1'b0;
    n = 1;
    while (!w_out_valid && n < 20) begin @(negedge clk); n++; end
    total++; if (n != 2) begin bad++; $display("FAIL wrap_latency: got %0d want 2", n); end
    total++; if (w_out_data !== 16'h8000) begin bad++; $display("FAIL wrap_data: got %h want 8000", w_out_data); end
    total++; if (w_flag !== 3'b101) begin bad++; $display("FAIL wrap_flag: got %b want 101", w_flag); end
  endtask

  task automatic test_random();
    logic [15:0] qd[$];
    logic [2:0]  qf[$];
    logic [15:0] mr;
    logic        hold;
    hold = 1'b0;
    for (int c = 0; c < 400 + 12; c++) begin
      @(negedge clk);
      if (c >= 400) begin
        in_valid = 1'b0; out_ready = 1'b1;
      end else begin
        if (!hold) begin
          in_valid = ($urandom_range(0, 9) < 7);
          op = 3'($urandom_range(0, 7));
          in1 = pick(); in2 = pick();
        end
        out_ready = ($urandom_range(0, 9) < 6);
      end
      #1;
      if (out_valid && out_ready) begin
        total++;
        if (qd.size() == 0) begin
          bad++; $display("FAIL rand_spurious: got output %h want none", out_data);
        end else begin
          if (out_data !== qd[0] || flag !== qf[0]) begin
            bad++; $display("FAIL rand_result: got %h/%b want %h/%b", out_data, flag, qd[0], qf[0]);
          end
          void'(qd.pop_front()); void'(qf.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        ref_op(op, in1, in2, mflag, mr, mflag);
        qd.push_back(mr); qf.push_back(mflag);
        hold = 1'b0;
      end else begin
        hold = in_valid;
      end
    end
    total++; if (qd.size() != 0) begin bad++; $display("FAIL rand_drain: got %0d pending want 0", qd.size()); end
  endtask

  task automatic test_backpressure();
    logic [15:0] qd[$];
    logic [2:0]  qf[$];
    logic [2:0]  bo [4];
    logic [15:0] ba [4], bb [4];
    logic [15:0] mr;
    int acc, got;
    bo = '{3'd0, 3'd3, 3'd1, 3'd4};
    ba = '{16'h1000, 16'h5A5A, 16'h0003, 16'h0011};
    bb = '{16'h0234, 16'hFFFF, 16'h0009, 16'h0003};
    acc = 0; got = 0;
    @(negedge clk);
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; op = bo[acc]; in1 = ba[acc]; in2 = bb[acc];
      #1;
      if (c >= 2) begin
        total++;
        if (!out_valid || out_data !== qd[0]) begin
          bad++; $display("FAIL bp_hold[%0d]: got %b/%h want 1/%h", c, out_valid, out_data, qd[0]);
        end
      end
      if (in_valid && in_ready) begin
        ref_op(op, in1, in2, mflag, mr, mflag);
        qd.push_back(mr); qf.push_back(mflag);
        acc++;
      end
      @(negedge clk);
    end
    total++; if (acc != 2) begin bad++; $display("FAIL bp_accepts: got %0d want 2", acc); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      in_valid = (acc < 4);
      if (acc < 4) begin op = bo[acc]; in1 = ba[acc]; in2 = bb[acc]; end
      #1;
      if (out_valid && out_ready) begin
        total++;
        if (qd.size() == 0) begin
          bad++; $display("FAIL bp_spurious: got output %h want none", out_data);
        end else begin
          if (out_data !== qd[0] || flag !== qf[0]) begin
            bad++; $display("FAIL bp_order[%0d]: got %h/%b want %h/%b", got, out_data, flag, qd[0], qf[0]);
          end
          void'(qd.pop_front()); void'(qf.pop_front());
          got++;
        end
      end
      if (in_valid && in_ready) begin
        ref_op(op, in1, in2, mflag, mr, mflag);
        qd.push_back(mr); qf.push_back(mflag);
        acc++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    total++; if (got != 4) begin bad++; $display("FAIL bp_count: got %0d want 4", got); end
  endtask

  task automatic test_flush();
    logic [15:0] mr;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; op = 3'd0; in1 = 16'h0100; in2 = 16'h0200;
    ref_op(op, in1, in2, mflag, mr, mflag);
    @(negedge clk);
    op = 3'd1; in1 = 16'h0005; in2 = 16'h0005;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_second_accept: got %b want 1", in_ready); end
    @(negedge clk);
    op = 3'd0; in1 = 16'h7FFF; in2 = 16'h0001;
    flush = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
    total++; if (out_valid !== 1'b1 || out_data !== mr) begin bad++; $display("FAIL flush_pre_out: got %b/%h want 1/%h", out_valid, out_data, mr); end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
    total++; if (flag !== mflag) begin bad++; $display("FAIL flush_flag: got %b want %b", flag, mflag); end
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (out_valid !== 1'b0 || flag !== mflag) begin bad++; $display("FAIL flush_after: got %b/%b want 0/%b", out_valid, flag, mflag); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] r;
    logic [2:0] f;
    logic [15:0] mr;
    int lat;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; op = 3'd0; in1 = 16'h7FFF; in2 = 16'h0001;
    ref_op(op, in1, in2, mflag, mr, mflag);
    @(negedge clk);
    op = 3'd3; in1 = 16'h0001; in2 = 16'h0002;
    @(negedge clk);
    in_valid = 1'b0;
    total++; if (flag !== mflag || out_valid !== 1'b1) begin bad++; $display("FAIL rstmid_pre: got %b/%b want %b/1", flag, out_valid, mflag); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (flag !== 3'b000) begin bad++; $display("FAIL rstmid_flag: got %b want 000", flag); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid); end
    total++; if (out_data !== 16'h0) begin bad++; $display("FAIL rstmid_out_data: got %h want 0000", out_data); end
    @(negedge clk);
    rst = 1'b0;
    mflag = 3'b000;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready); end
    run_one(3'd0, 16'h0001, 16'h0001, r, f, lat);
    total++; if (r !== 16'h0002 || f !== 3'b000 || lat != 2) begin
      bad++; $display("FAIL rstmid_resume: got %h/%b/%0d want 0002/000/2", r, f, lat);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_sat_off();
    test_random();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
